// File: rtl/mem_arb_pkg.sv
// Shared encodings and sizing helpers for the memory port arbiter.
package mem_arb_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StAcc  = ACC,
    StResp = RESP
  } state_e;

  // Owner encoding
  localparam logic OWN_C = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Owner selection between CPU (C) and loader (D) plus the D starvation counter.
// C has priority unless D has been blocked for MAX_WAIT cycles.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8,
  localparam int unsigned WW      = cnt_width(MAX_WAIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic c_req,
  input  logic d_req,
  input  logic idle,        // arbiter FSM is in IDLE
  input  logic d_owns,      // an access is in flight and D owns it
  output logic grant,       // a grant happens this cycle
  output logic grant_owner  // owner chosen if grant is taken
);

  logic [WW-1:0] wait_q, wait_d;
  logic          starved;

  assign starved = (wait_q == WW'(MAX_WAIT));

  // Owner select: D wins when alone or when starved, otherwise C.
  always_comb begin
    grant_owner = OWN_C;
    if (d_req && (!c_req || starved)) begin
      grant_owner = OWN_D;
    end
    grant = idle && (c_req || d_req);
  end

  // Starvation count: grows while D waits, clears on D grant or D idle.
  always_comb begin
    wait_d = wait_q;
    if (!d_req) begin
      wait_d = '0;
    end else if (idle && (grant_owner == OWN_D)) begin
      wait_d = '0;
    end else if (idle || !d_owns) begin
      wait_d = starved ? wait_q : wait_q + WW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory between the CPU controller (C) and a debug/DMA loader (D).
// Each access runs IDLE -> ACC (MEM_LAT cycles) -> RESP, giving one bubble between accesses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 32,
  parameter int unsigned MEM_LAT  = 2,   // must be >= 1
  parameter int unsigned MAX_WAIT = 8    // must be >= 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant_d
);

  localparam int unsigned LatW = cnt_width(MEM_LAT - 1);

  state_e          state_q, state_d;
  logic [LatW-1:0] lat_q, lat_d;
  logic            owner_q, owner_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            gnt_d_q, gnt_d_d;

  logic            in_idle;
  logic            d_owns;
  logic            grant;
  logic            grant_owner;
  logic            lat_last;

  assign in_idle  = (state_q == StIdle);
  assign d_owns   = !in_idle && (owner_q == OWN_D);
  assign lat_last = (lat_q == LatW'(MEM_LAT - 1));

  mem_arb_prio #(
    .MAX_WAIT (MAX_WAIT)
  ) u_prio (
    .clk         (clk),
    .rst_n       (rst_n),
    .c_req       (c_req),
    .d_req       (d_req),
    .idle        (in_idle),
    .d_owns      (d_owns),
    .grant       (grant),
    .grant_owner (grant_owner)
  );

  // Next-state: grant and latch in IDLE, count latency in ACC, single RESP cycle.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gnt_d_d = gnt_d_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          owner_d = grant_owner;
          gnt_d_d = (grant_owner == OWN_D);
          lat_d   = '0;
          state_d = StAcc;
          if (grant_owner == OWN_D) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            we_d    = c_we;
            addr_d  = c_addr;
            wdata_d = c_wdata;
          end
        end
      end
      StAcc: begin
        if (lat_last) begin
          // Writes return zero data.
          rdata_d = we_q ? '0 : mem_rdata;
          state_d = StResp;
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Memory strobes and per-port responses, all decoded from registered state.
  always_comb begin
    mem_en    = (state_q == StAcc);
    // Write strobe only on the first ACC cycle so a write commits exactly once.
    mem_we    = mem_en && we_q && (lat_q == '0);
    mem_addr  = mem_en ? addr_q : '0;
    mem_wdata = mem_en ? wdata_q : '0;
    c_ack     = (state_q == StResp) && (owner_q == OWN_C);
    d_ack     = (state_q == StResp) && (owner_q == OWN_D);
    c_rdata   = c_ack ? rdata_q : '0;
    d_rdata   = d_ack ? rdata_q : '0;
    grant_d   = gnt_d_q;
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lat_q   <= '0;
      owner_q <= OWN_C;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gnt_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      gnt_d_q <= gnt_d_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=2 and MEM_LAT=1) share one stimulus
// stream, each backed by its own memory and checked every cycle against a behavioural model.
module tb_mem_port_arbiter;

  localparam int AW       = 10;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 8;
  localparam int LAT0     = 2;
  localparam int LAT1     = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] c_addr = '0, d_addr = '0;
  logic [DW-1:0] c_wdata = '0, d_wdata = '0;

  logic          c_ack [2];
  logic          d_ack [2];
  logic [DW-1:0] c_rdata [2];
  logic [DW-1:0] d_rdata [2];
  logic          mem_en [2];
  logic          mem_we [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic          grant_d [2];

  // Memory devices seen by the DUTs, and the model's own view of memory.
  logic [DW-1:0] bmem [2][1024];
  logic [DW-1:0] mmem [2][1024];

  // Behavioural model: phase 0 idle, 1..L memory cycles, L+1 response.
  int            m_phase [2];
  int            m_wait  [2];
  bit            m_owner [2];
  bit            m_we    [2];
  bit            m_gd    [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic [DW-1:0] m_rd    [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign mem_rdata[0] = bmem[0][mem_addr[0]];
  assign mem_rdata[1] = bmem[1][mem_addr[1]];

  mem_port_arbiter #(
    .AW (AW), .DW (DW), .MEM_LAT (LAT0), .MAX_WAIT (MAX_WAIT)
  ) u_dut0 (
    .clk (clk), .rst_n (rst_n),
    .c_req (c_req), .c_we (c_we), .c_addr (c_addr), .c_wdata (c_wdata),
    .c_ack (c_ack[0]), .c_rdata (c_rdata[0]),
    .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata),
    .d_ack (d_ack[0]), .d_rdata (d_rdata[0]),
    .mem_en (mem_en[0]), .mem_we (mem_we[0]), .mem_addr (mem_addr[0]),
    .mem_wdata (mem_wdata[0]), .mem_rdata (mem_rdata[0]), .grant_d (grant_d[0])
  );

  mem_port_arbiter #(
    .AW (AW), .DW (DW), .MEM_LAT (LAT1), .MAX_WAIT (MAX_WAIT)
  ) u_dut1 (
    .clk (clk), .rst_n (rst_n),
    .c_req (c_req), .c_we (c_we), .c_addr (c_addr), .c_wdata (c_wdata),
    .c_ack (c_ack[1]), .c_rdata (c_rdata[1]),
    .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata),
    .d_ack (d_ack[1]), .d_rdata (d_rdata[1]),
    .mem_en (mem_en[1]), .mem_we (mem_we[1]), .mem_addr (mem_addr[1]),
    .mem_wdata (mem_wdata[1]), .mem_rdata (mem_rdata[1]), .grant_d (grant_d[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(input string name, input int k, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  function automatic logic [127:0] act_vec(input int k);
    return {17'd0, mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k], c_ack[k], c_rdata[k],
            d_ack[k], d_rdata[k], grant_d[k]};
  endfunction

  function automatic logic [127:0] exp_vec(input int k);
    int            l;
    logic          en, we, ca, da;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew, cr, dr;
    l  = lat_of(k);
    en = (m_phase[k] >= 1) && (m_phase[k] <= l);
    we = (m_phase[k] == 1) && m_we[k];
    ca = (m_phase[k] == l + 1) && !m_owner[k];
    da = (m_phase[k] == l + 1) && m_owner[k];
    ea = en ? m_addr[k] : '0;
    ew = en ? m_wdata[k] : '0;
    cr = ca ? m_rd[k] : '0;
    dr = da ? m_rd[k] : '0;
    return {17'd0, en, we, ea, ew, ca, cr, da, dr, m_gd[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0;
      m_wait[k]  = 0;
      m_gd[k]    = 1'b0;
    end
  endtask

  // One clock of the arbiter's contract for instance k.
  task automatic model_step(input int k);
    int l;
    bit dwin;
    l = lat_of(k);
    if (m_phase[k] == 0) begin
      dwin = d_req && (!c_req || (m_wait[k] == MAX_WAIT));
      if (dwin || c_req) begin
        m_owner[k] = dwin;
        m_gd[k]    = dwin;
        m_we[k]    = dwin ? d_we : c_we;
        m_addr[k]  = dwin ? d_addr : c_addr;
        m_wdata[k] = dwin ? d_wdata : c_wdata;
        m_rd[k]    = m_we[k] ? '0 : mmem[k][m_addr[k]];
        m_phase[k] = 1;
      end
      if (!d_req || dwin) m_wait[k] = 0;
      else if (m_wait[k] < MAX_WAIT) m_wait[k]++;
    end else begin
      if (m_phase[k] == 1 && m_we[k]) mmem[k][m_addr[k]] = m_wdata[k];
      if (!d_req) m_wait[k] = 0;
      else if (!m_owner[k] && m_wait[k] < MAX_WAIT) m_wait[k]++;
      m_phase[k] = (m_phase[k] == l + 1) ? 0 : m_phase[k] + 1;
    end
  endtask

  // Memory devices and model advance on the clock; asynchronous reset clears the model.
  initial begin
    logic [DW-1:0] v;
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 1024; a++) begin
        v = $urandom;
        bmem[k][a] = v;
        mmem[k][a] = v;
      end
      bmem[k][4] = 32'hDEAD_BEEF;
      mmem[k][4] = 32'hDEAD_BEEF;
    end
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (mem_we[k]) bmem[k][mem_addr[k]] <= mem_wdata[k];
          model_step(k);
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk("cycle outputs", k, act_vec(k), exp_vec(k));
    end
  end

  task automatic drive(input bit is_d, input bit req, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
    if (is_d) begin
      d_req = req; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      c_req = req; c_we = we; c_addr = addr; c_wdata = wdata;
    end
  endtask

  task automatic settle();
    @(posedge clk); #1;
    c_req = 1'b0;
    d_req = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  // Single access on one port, measured on instance k against literal expectations.
  task automatic run_one(input int k, input bit is_d, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                         input string tag);
    int            n = 0, en_cnt = 0, we_cnt = 0;
    bit            got = 1'b0, other = 1'b0;
    logic [DW-1:0] rd = '0;
    @(posedge clk); #1;
    drive(is_d, 1'b1, we, addr, wdata);
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_en[k]) en_cnt++;
      if (mem_we[k]) begin
        we_cnt++;
        chk({tag, " write addr/data"}, k, 128'({mem_addr[k], mem_wdata[k]}),
            128'({addr, wdata}));
      end
      if (is_d ? c_ack[k] : d_ack[k]) other = 1'b1;
      if (is_d ? d_ack[k] : c_ack[k]) begin
        got = 1'b1;
        rd  = is_d ? d_rdata[k] : c_rdata[k];
      end
    end
    @(posedge clk); #1;
    drive(is_d, 1'b0, 1'b0, '0, '0);
    chk({tag, " ack latency"}, k, 128'(n), 128'(lat_of(k) + 2));
    chk({tag, " mem_en cycles"}, k, 128'(en_cnt), 128'(lat_of(k)));
    chk({tag, " mem_we cycles"}, k, 128'(we_cnt), 128'(we));
    chk({tag, " rdata"}, k, 128'(rd), 128'(exp_rd));
    chk({tag, " other ack"}, k, 128'(other), 128'(0));
    settle();
  endtask

  initial begin
    int  n, cacks, gap, wes, first;
    bit  got;

    // Reset held with toggling requests: everything stays 0.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      c_req = ~c_req;
      d_req = (i % 2 == 0);
      @(negedge clk);
      chk("reset outputs", 0, act_vec(0) | act_vec(1), 128'(0));
    end
    @(posedge clk); #1;
    c_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle after reset", 0, 128'({mem_en[0], mem_en[1]}), 128'(0));
    end

    // Single reads and writes on both latencies.
    run_one(0, 1'b0, 1'b0, 10'h004, 32'h0, 32'hDEAD_BEEF, "C read");
    run_one(1, 1'b0, 1'b0, 10'h004, 32'h0, 32'hDEAD_BEEF, "C read");
    run_one(0, 1'b1, 1'b1, 10'h010, 32'h1234_5678, 32'h0, "D write");
    run_one(1, 1'b1, 1'b1, 10'h010, 32'h1234_5678, 32'h0, "D write");
    run_one(1, 1'b0, 1'b0, 10'h010, 32'h0, 32'h1234_5678, "C readback");

    // Contention: C held continuously, D granted once its wait reaches MAX_WAIT.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 10'h001, '0);
    drive(1'b1, 1'b1, 1'b0, 10'h002, '0);
    n = 0; cacks = 0;
    while (!grant_d[0] && n < 40) begin
      @(negedge clk);
      n++;
      if (c_ack[0]) cacks++;
    end
    chk("D grant cycle", 0, 128'(n), 128'(10));
    chk("C acks before D", 0, 128'(cacks), 128'(2));
    got = 1'b0; n = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      got = d_ack[0];
    end
    chk("D ack after grant", 0, 128'(got), 128'(1));
    settle();

    // Withdrawal during ACC: the ack still arrives.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 10'h003, '0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    c_req = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 6) begin
      @(negedge clk);
      n++;
      got = c_ack[0];
    end
    chk("ack after withdraw", 0, 128'(got), 128'(1));
    settle();

    // Reset in the second ACC cycle of a write: no ack, but the write has committed.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 10'h005, 32'hA5A5_0005);
    n = 0;
    while (!mem_en[0] && n < 6) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    rst_n = 1'b0; c_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("no ack in reset", 0, 128'({c_ack[0], d_ack[0], mem_en[0]}), 128'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle after mid-ACC reset", 0, 128'({mem_en[0], c_ack[0]}), 128'(0));
    end
    run_one(0, 1'b0, 1'b0, 10'h005, 32'h0, 32'hA5A5_0005, "committed write");

    // Back-to-back: C keeps requesting, two accesses with one bubble, one write each.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 10'h006, 32'h0606_0606);
    n = 0; cacks = 0; wes = 0; first = 0; gap = 0;
    while (cacks < 2 && n < 30) begin
      @(negedge clk);
      n++;
      if (mem_we[0]) wes++;
      if (c_ack[0]) begin
        cacks++;
        if (cacks == 1) first = n;
        else gap = n - first;
      end
    end
    @(posedge clk); #1;
    c_req = 1'b0;
    chk("back-to-back gap", 0, 128'(gap), 128'(LAT0 + 2));
    chk("back-to-back writes", 0, 128'(wes), 128'(2));
    settle();

    // Random traffic with sticky requests and occasional asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 249) != 0);
      if ($urandom_range(0, 4) == 0) c_req = ~c_req;
      if ($urandom_range(0, 5) == 0) d_req = ~d_req;
      if ($urandom_range(0, 2) == 0) begin
        c_we    = 1'($urandom_range(0, 1));
        c_addr  = AW'($urandom_range(0, 15));
        c_wdata = $urandom;
      end
      if ($urandom_range(0, 2) == 0) begin
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = AW'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
